// File: rtl/dmem_model_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_req_t / mem_rsp_t are sized for the widest legal DATA_W (64); narrower
//   instances use the low bits only.
package dmem_model_pkg;

  localparam logic [63:0] TOHOST_PASS = 64'd1;

  typedef struct packed {
    logic        we;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } mem_rsp_t;

  // Word index relative to the base of the mapped window.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned shift);
    return (addr - base) >> shift;
  endfunction

  // Below-base addresses would wrap in the subtraction, so test them first.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth,
                                         input int unsigned shift);
    return (addr >= base) && (word_index(addr, base, shift) < depth);
  endfunction

endpackage

// File: rtl/rsp_delay_line.sv
// LATENCY-deep shift register carrying {valid, response}.
//   clk, rst_n      : clock, async active-low reset (clears all stages)
//   in_vld, in_rsp  : stage-0 input
//   out_vld, out_rsp: last-stage output
module rsp_delay_line
  import dmem_model_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_vld,
  input  mem_rsp_t in_rsp,
  output logic     out_vld,
  output mem_rsp_t out_rsp
);

  logic [LATENCY-1:0] vld_pipe;
  mem_rsp_t           rsp_pipe [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) rsp_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      rsp_pipe[0] <= in_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[LATENCY-1];
  assign out_rsp = rsp_pipe[LATENCY-1];

endmodule

// File: rtl/dmem_resp_model.sv
// Data-memory responder for the core bench: grant/backpressure, fixed response
// latency, bounded outstanding requests, periodic stall injection, error
// response for unmapped addresses and a sticky tohost pass/fail monitor.
//   clk, rst_n                   : clock, async active-low reset
//   req, we, be, addr, wdata     : request (accepted when req && gnt)
//   gnt                          : combinational grant
//   rvalid, rdata, err           : in-order response, one per accepted request
//   done, pass, fail_code        : sticky tohost result
module dmem_resp_model
  import dmem_model_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter int          DEPTH_WORDS     = 65536,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          STALL_EVERY     = 0,
  parameter logic [31:0] TOHOST_ADDR     = 32'h8000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              gnt,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              done,
  output logic              pass,
  output logic [30:0]       fail_code
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_req_t          rq;
  mem_rsp_t          cap_rsp, s_rsp, o_rsp;
  logic              s_vld;
  logic              acc, in_rng, stall, th_hit;
  logic [AW-1:0]     idx;
  logic [3:0]        outst;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_comb begin
    rq                    = '0;
    rq.we                 = we;
    rq.be[BYTES-1:0]      = be;
    rq.addr               = addr;
    rq.wdata[DATA_W-1:0]  = wdata;
  end

  assign in_rng = addr_in_range(rq.addr, BASE_ADDR, DEPTH_WORDS, SHIFT);
  assign idx    = AW'(word_index(rq.addr, BASE_ADDR, SHIFT));
  assign gnt    = rst_n && (outst < 4'(MAX_OUTSTANDING)) && !stall;
  assign acc    = req && gnt;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (acc && rq.we && in_rng)
      for (int b = 0; b < BYTES; b++)
        if (rq.be[b]) mem[idx][8*b +: 8] <= rq.wdata[8*b +: 8];
  end

  // Response is formed from storage as seen before the accept edge, so a
  // write accepted one cycle earlier is already visible.
  always_comb begin
    cap_rsp     = '0;
    cap_rsp.err = !in_rng;
    if (!rq.we && in_rng) cap_rsp.rdata[DATA_W-1:0] = mem[idx];
  end

  // Capture stage at the accept edge; the delay line adds LATENCY more edges.
  // Idle slots carry zeros, which keeps rdata/err at 0 whenever rvalid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld <= 1'b0;
      s_rsp <= '0;
    end else begin
      s_vld <= acc;
      s_rsp <= acc ? cap_rsp : '0;
    end
  end

  rsp_delay_line #(.LATENCY(LATENCY)) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (s_vld),
    .in_rsp  (s_rsp),
    .out_vld (rvalid),
    .out_rsp (o_rsp)
  );

  assign rdata = o_rsp.rdata[DATA_W-1:0];
  assign err   = o_rsp.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outst <= '0;
    else begin
      case ({acc, rvalid})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: ;
      endcase
    end
  end

  generate
    if (STALL_EVERY > 0) begin : g_stall
      logic [15:0] acc_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_cnt <= '0;
          stall   <= 1'b0;
        end else begin
          stall <= 1'b0;
          if (acc) begin
            if (acc_cnt == 16'(STALL_EVERY - 1)) begin
              acc_cnt <= '0;
              stall   <= 1'b1;
            end else begin
              acc_cnt <= acc_cnt + 16'd1;
            end
          end
        end
      end
    end else begin : g_nostall
      assign stall = 1'b0;
    end
  endgenerate

  // First qualifying nonzero tohost write wins; done gates later ones.
  assign th_hit = acc && rq.we && (rq.addr == TOHOST_ADDR) && (&be) && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
    end else if (th_hit && (wdata != '0)) begin
      done <= 1'b1;
      if (wdata == DATA_W'(TOHOST_PASS)) pass <= 1'b1;
      else                               fail_code <= wdata[31:1];
    end
  end

  // Upper struct bits are unused for narrower DATA_W.
  logic unused;
  assign unused = ^{rq, o_rsp};

endmodule

// File: tb/tb_dmem_resp_model.sv
module tb_dmem_resp_model;

  localparam logic [31:0] TH = 32'h8000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: LATENCY=3, MAX_OUTSTANDING=4
  logic        req_a = 0, we_a = 0;
  logic [3:0]  be_a = 0;
  logic [31:0] addr_a = 0, wdata_a = 0;
  logic        gnt_a, rvalid_a, err_a, done_a, pass_a;
  logic [31:0] rdata_a;
  logic [30:0] fail_a;

  // instances B (backpressure) and C (stall) share write stimulus
  logic        req_b = 0, req_c = 0;
  logic        we_bc = 1;
  logic [3:0]  be_bc = 4'hF;
  logic [31:0] addr_bc = 32'h8000_0100, wdata_bc = 32'h0;
  logic        gnt_b, rvalid_b, err_b, done_b, pass_b;
  logic        gnt_c, rvalid_c, err_c, done_c, pass_c;
  logic [31:0] rdata_b, rdata_c;
  logic [30:0] fail_b, fail_c;

  dmem_resp_model #(.DEPTH_WORDS(2048), .LATENCY(3), .MAX_OUTSTANDING(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .be(be_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a),
    .done(done_a), .pass(pass_a), .fail_code(fail_a));

  dmem_resp_model #(.DEPTH_WORDS(2048), .LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_bc), .be(be_bc), .addr(addr_bc),
    .wdata(wdata_bc), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b),
    .done(done_b), .pass(pass_b), .fail_code(fail_b));

  dmem_resp_model #(.DEPTH_WORDS(2048), .LATENCY(1), .MAX_OUTSTANDING(8),
                    .STALL_EVERY(3)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .we(we_bc), .be(be_bc), .addr(addr_bc),
    .wdata(wdata_bc), .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .err(err_c),
    .done(done_c), .pass(pass_c), .fail_code(fail_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One isolated request on A; response must appear exactly 3 edges after accept.
  task automatic a_op(input string tag, input logic w, input logic [3:0] b,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eer);
    @(negedge clk);
    req_a = 1; we_a = w; be_a = b; addr_a = ad; wdata_a = wd;
    chk({tag, "_gnt"}, gnt_a, 1);
    @(negedge clk);
    req_a = 0;
    chk({tag, "_early0"}, rvalid_a, 0);
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_early"}, rvalid_a, 0);
    end
    @(negedge clk);
    chk({tag, "_rvalid"}, rvalid_a, 1);
    chk({tag, "_rdata"}, rdata_a, erd);
    chk({tag, "_err"}, err_a, eer);
  endtask

  logic [13:0] exp_gb, exp_vb;
  logic [15:0] gh;
  int acc_b, rsp_b, acc_c, rsp_c;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_gnt", gnt_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_fail", fail_a, 0);
    rst_n = 1;
    @(negedge clk);
    chk("gnt_after_rst", gnt_a, 1);

    // write then read on the next cycle
    req_a = 1; we_a = 1; be_a = 4'hF; addr_a = 32'h8000_0010; wdata_a = 32'hDEAD_BEEF;
    @(negedge clk);
    we_a = 0;
    @(negedge clk);
    req_a = 0;
    @(negedge clk);
    chk("b2b_early", rvalid_a, 0);
    @(negedge clk);
    chk("b2b_wr_rvalid", rvalid_a, 1);
    chk("b2b_wr_rdata", rdata_a, 0);
    chk("b2b_wr_err", err_a, 0);
    @(negedge clk);
    chk("b2b_rd_rvalid", rvalid_a, 1);
    chk("b2b_rd_rdata", rdata_a, 32'hDEAD_BEEF);
    chk("b2b_rd_err", err_a, 0);
    @(negedge clk);
    chk("b2b_idle", rvalid_a, 0);
    chk("b2b_idle_rdata", rdata_a, 0);

    // byte-enable merge and be=0 no-op
    a_op("bm_w0", 1, 4'hF, 32'h8000_0020, 32'hFFFF_FFFF, 0, 0);
    a_op("bm_w1", 1, 4'h4, 32'h8000_0020, 32'h00AB_0000, 0, 0);
    a_op("bm_rd", 0, 4'h0, 32'h8000_0020, 0, 32'hFFAB_FFFF, 0);
    a_op("be0_w", 1, 4'h0, 32'h8000_0020, 32'h1234_5678, 0, 0);
    a_op("be0_rd", 0, 4'h0, 32'h8000_0020, 0, 32'hFFAB_FFFF, 0);

    // range boundaries; an out-of-range write must not alias word 0
    a_op("w0", 1, 4'hF, 32'h8000_0000, 32'h1111_1111, 0, 0);
    a_op("oor_lo", 0, 4'hF, 32'h7FFF_FFFC, 0, 0, 1);
    a_op("oor_hi_w", 1, 4'hF, 32'h8000_2000, 32'h0BAD_0BAD, 0, 1);
    a_op("oor_hi_r", 0, 4'hF, 32'h8000_2000, 0, 0, 1);
    a_op("w0_keep", 0, 4'hF, 32'h8000_0000, 0, 32'h1111_1111, 0);
    a_op("last_w", 1, 4'hF, 32'h8000_1FFC, 32'hCAFE_F00D, 0, 0);
    a_op("last_r", 0, 4'hF, 32'h8000_1FFC, 0, 32'hCAFE_F00D, 0);

    // tohost monitor
    a_op("th_part", 1, 4'h7, TH, 32'd1, 0, 0);
    chk("th_part_done", done_a, 0);
    a_op("th_zero", 1, 4'hF, TH, 32'd0, 0, 0);
    chk("th_zero_done", done_a, 0);
    a_op("th_fail", 1, 4'hF, TH, 32'd7, 0, 0);
    chk("th_fail_done", done_a, 1);
    chk("th_fail_pass", pass_a, 0);
    chk("th_fail_code", fail_a, 3);
    a_op("th_late", 1, 4'hF, TH, 32'd1, 0, 0);
    chk("th_late_done", done_a, 1);
    chk("th_late_pass", pass_a, 0);
    chk("th_late_code", fail_a, 3);
    a_op("th_store", 0, 4'hF, TH, 0, 32'd1, 0);

    // backpressure on B: LATENCY=4, MAX_OUTSTANDING=2, req held high
    exp_gb = 14'b11000011000011;
    exp_vb = 14'b01100001100000;
    acc_b = 0; rsp_b = 0;
    @(negedge clk);
    req_b = 1;
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      chk("b_gnt", gnt_b, exp_gb[i]);
      chk("b_rvalid", rvalid_b, exp_vb[i]);
      if (gnt_b) acc_b++;
      if (rvalid_b) rsp_b++;
      chk("b_outst_le2", (acc_b - rsp_b) <= 2, 1);
    end
    @(negedge clk);
    req_b = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      if (rvalid_b) rsp_b++;
    end
    chk("b_accepts", acc_b, 6);
    chk("b_all_resp", rsp_b, acc_b);

    // stall injection on C: STALL_EVERY=3, LATENCY=1
    acc_c = 0; rsp_c = 0; gh = '0;
    @(negedge clk);
    req_c = 1;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      gh[i] = gnt_c;
      chk("c_gnt", gnt_c, (i % 4) != 3);
      chk("c_rvalid", rvalid_c, (i >= 2) ? gh[i-2] : 1'b0);
      if (rvalid_c) chk("c_err", err_c, 0);
      if (gnt_c) acc_c++;
      if (rvalid_c) rsp_c++;
    end
    @(negedge clk);
    req_c = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      if (rvalid_c) rsp_c++;
    end
    chk("c_accepts", acc_c, 9);
    chk("c_all_resp", rsp_c, acc_c);
    chk("bc_idle", {rvalid_b, rvalid_c, err_b, err_c, done_b, done_c, pass_b, pass_c}, 0);
    chk("bc_idle_data", {rdata_b, rdata_c, fail_b, fail_c}, 0);

    // reset with two reads in flight on A
    @(negedge clk);
    req_a = 1; we_a = 0; be_a = 4'hF; addr_a = 32'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    req_a = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_gnt", gnt_a, 0);
    chk("mid_rst_rvalid", rvalid_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_pass", pass_a, 0);
    chk("mid_rst_fail", fail_a, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", rvalid_a, 0);
    end
    chk("post_rst_done", done_a, 0);
    a_op("mem_kept", 0, 4'hF, 32'h8000_0000, 0, 32'h1111_1111, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
